my_half_subtractor: RTL and testbench

Registered, parameterisable bank of half-subtractor lanes with an optional ripple-borrow mode. In ripple-borrow mode the lanes form a WIDTH-bit X-minus-Y subtractor. Sits in the datapath as a one-cycle arithmetic stage with valid qualification and a saturating borrow-event counter for status. With WIDTH=1 and chain=0 it is the classic 1-bit half subtractor (diff = X xor Y, bout = not X and Y) with a registered output.

---
 rtl/my_half_subtractor.sv | 67 ++++++
 tb/tb_my_half_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/my_half_subtractor.sv
// Registered bank of half-subtractor lanes with optional ripple-borrow chaining
// and a saturating count of accepted samples that produced a borrow.
module my_half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             chain,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] bout,
  output logic [CNT_W-1:0] borrow_count
);

  logic [WIDTH-1:0] diff_d, diff_q;
  logic [WIDTH-1:0] bout_d, bout_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             valid_q;
  logic             borrow_event;

  // Lane 0 always sees a zero borrow-in, so it degenerates to a half subtractor;
  // with chain=0 every lane does.
  always_comb begin
    logic b_in;
    diff_d = '0;
    bout_d = '0;
    b_in   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff_d[i] = X[i] ^ Y[i] ^ b_in;
      bout_d[i] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & b_in);
      b_in      = chain & bout_d[i];
    end
    borrow_event = chain ? bout_d[WIDTH-1] : |bout_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && borrow_event && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      bout_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= in_valid;
      cnt_q   <= cnt_d;
      if (in_valid) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
      end
    end
  end

  assign out_valid    = valid_q;
  assign diff         = diff_q;
  assign bout         = bout_q;
  assign borrow_count = cnt_q;

endmodule

// File: tb/tb_my_half_subtractor.sv
// Directed self-checking bench: a 1-lane instance, a 4-lane instance and a
// 1-lane instance with a 2-bit counter to exercise saturation.
module tb_my_half_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 1-lane, default counter
  logic        v1 = 1'b0, c1 = 1'b0;
  logic [0:0]  x1 = '0, y1 = '0;
  logic        ov1;
  logic [0:0]  d1, b1;
  logic [15:0] n1;

  // 4-lane
  logic        v4 = 1'b0, c4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic        ov4;
  logic [3:0]  d4, b4;
  logic [15:0] n4;

  // 1-lane, 2-bit counter
  logic        vs = 1'b0, cs = 1'b0;
  logic [0:0]  xs = '0, ys = '0;
  logic        ovs;
  logic [0:0]  ds, bs;
  logic [1:0]  ns;

  my_half_subtractor #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .chain(c1), .X(x1), .Y(y1),
    .out_valid(ov1), .diff(d1), .bout(b1), .borrow_count(n1));

  my_half_subtractor #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .chain(c4), .X(x4), .Y(y4),
    .out_valid(ov4), .diff(d4), .bout(b4), .borrow_count(n4));

  my_half_subtractor #(.WIDTH(1), .CNT_W(2)) duts (
    .clk(clk), .rst(rst), .in_valid(vs), .chain(cs), .X(xs), .Y(ys),
    .out_valid(ovs), .diff(ds), .bout(bs), .borrow_count(ns));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({ov1, d1, b1} !== 3'b000 || n1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_w1 got ov=%b d=%b b=%b cnt=%0d want 0 0 0 0", ov1, d1, b1, n1);
    end
    checks++;
    if (ov4 !== 1'b0 || d4 !== 4'h0 || b4 !== 4'h0 || n4 !== 16'd0) begin
      failures++;
      $display("FAIL reset_w4 got ov=%b d=%b b=%b cnt=%0d want 0 0000 0000 0", ov4, d4, b4, n4);
    end
    checks++;
    if ({ovs, ds, bs} !== 3'b000 || ns !== 2'd0) begin
      failures++;
      $display("FAIL reset_sat got ov=%b d=%b b=%b cnt=%0d want 0 0 0 0", ovs, ds, bs, ns);
    end
  endtask

  // XY = 00,10,01,11; chain toggled to show it has no effect at WIDTH=1.
  task automatic test_truth_table();
    logic [1:0] xy_v [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic       ch_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_db [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1;
      c1 = ch_v[i];
      x1 = xy_v[i][1];
      y1 = xy_v[i][0];
      tick();
      checks++;
      if (ov1 !== 1'b1 || {d1, b1} !== exp_db[i]) begin
        failures++;
        $display("FAIL truth_%0d got ov=%b diff,bout=%b%b want 1 %b", i, ov1, d1, b1, exp_db[i]);
      end
    end
    v1 = 1'b0;
    tick();
    checks++;
    if (ov1 !== 1'b0 || n1 !== 16'd1 || {d1, b1} !== 2'b00) begin
      failures++;
      $display("FAIL truth_count got ov=%b cnt=%0d d,b=%b%b want 0 1 00", ov1, n1, d1, b1);
    end
  endtask

  task automatic test_reset_midstream();
    v1 = 1'b1; c1 = 1'b0; x1 = 1'b0; y1 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v1 = 1'b0;
    checks++;
    if ({ov1, d1, b1} !== 3'b000 || n1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got ov=%b d=%b b=%b cnt=%0d want 0 0 0 0", ov1, d1, b1, n1);
    end
    tick();
    checks++;
    if (n1 !== 16'd0 || ov1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after got ov=%b cnt=%0d want 0 0", ov1, n1);
    end
  endtask

  // Back-to-back 4-lane samples, switching chain mode without a bubble.
  task automatic test_back_to_back();
    logic       ch_v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] x_v  [5] = '{4'b0011, 4'b1001, 4'b0101, 4'b0000, 4'b1111};
    logic [3:0] y_v  [5] = '{4'b0101, 4'b0011, 4'b0110, 4'b0001, 4'b1111};
    logic [3:0] ed_v [5] = '{4'b1110, 4'b0110, 4'b0011, 4'b1111, 4'b0000};
    logic [3:0] eb_v [5] = '{4'b1100, 4'b0110, 4'b0010, 4'b1111, 4'b0000};
    int         en_v [5] = '{1, 1, 2, 3, 3};
    for (int i = 0; i < 5; i++) begin
      v4 = 1'b1;
      c4 = ch_v[i];
      x4 = x_v[i];
      y4 = y_v[i];
      tick();
      checks++;
      if (ov4 !== 1'b1 || d4 !== ed_v[i] || b4 !== eb_v[i] || n4 !== 16'(en_v[i])) begin
        failures++;
        $display("FAIL b2b_%0d got ov=%b diff=%b bout=%b cnt=%0d want 1 %b %b %0d",
                 i, ov4, d4, b4, n4, ed_v[i], eb_v[i], en_v[i]);
      end
    end
  endtask

  task automatic test_valid_gap();
    v4 = 1'b1; c4 = 1'b0; x4 = 4'b1010; y4 = 4'b0101;
    tick();
    checks++;
    if (ov4 !== 1'b1 || d4 !== 4'b1111 || b4 !== 4'b0101 || n4 !== 16'd4) begin
      failures++;
      $display("FAIL gap_sample got ov=%b diff=%b bout=%b cnt=%0d want 1 1111 0101 4", ov4, d4, b4, n4);
    end
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x4 = ~x4;
      y4 = 4'(y4 + 4'd3);
      c4 = ~c4;
      tick();
      checks++;
      if (ov4 !== 1'b0 || d4 !== 4'b1111 || b4 !== 4'b0101 || n4 !== 16'd4) begin
        failures++;
        $display("FAIL gap_hold_%0d got ov=%b diff=%b bout=%b cnt=%0d want 0 1111 0101 4",
                 i, ov4, d4, b4, n4);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_n [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      vs = 1'b1; cs = 1'(i & 1); xs = 1'b0; ys = 1'b1;
      tick();
      checks++;
      if (ns !== exp_n[i] || ovs !== 1'b1 || {ds, bs} !== 2'b11) begin
        failures++;
        $display("FAIL sat_%0d got cnt=%0d ov=%b d,b=%b%b want %0d 1 11", i, ns, ovs, ds, bs, exp_n[i]);
      end
    end
    vs = 1'b1; xs = 1'b1; ys = 1'b0;
    tick();
    vs = 1'b0;
    checks++;
    if (ns !== 2'd3 || {ds, bs} !== 2'b10) begin
      failures++;
      $display("FAIL sat_noborrow got cnt=%0d d,b=%b%b want 3 10", ns, ds, bs);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_reset_midstream();
    test_back_to_back();
    test_valid_gap();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
